// File: rtl/pwd_entry_ctrl.sv
// pwd_entry_ctrl -- keypad-style password entry controller.
//
// Three active-low pushbuttons (enter digit, clear, submit) are synchronised
// and debounced. Their press events drive an FSM that collects digits,
// checks them against a stored password, shows GRANTED / DENIED, and locks
// out after MAX_TRIES consecutive failures. While GRANTED, the stored
// password can be reprogrammed.
//
// Ports
//   ref_clk_clk      sole clock, rising edge
//   ref_reset_reset  asynchronous reset, active low
//   key_n[2:0]       pushbuttons, active low: [0] enter, [1] clear, [2] submit
//   digit_in         digit value, sampled on an enter event
//   prog_en          submit while GRANTED stores a new password
//   entry_buf        entered digits, newest digit in the LSBs
//   entry_cnt        number of digits entered (0..NUM_DIGITS)
//   state            IDLE=0 ENTRY=1 CHECK=2 GRANTED=3 DENIED=4 LOCKED=5
//   granted/denied/locked  registered state decodes
//   fail_cnt         consecutive failed attempts
//   pwd_updated      one-cycle pulse when the password is reprogrammed
module pwd_entry_ctrl #(
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned DIGIT_W         = 4,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_PWD = 16'h1234,
   parameter int unsigned MAX_TRIES       = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned LOCK_CYCLES     = 250000000,
   parameter int unsigned SHOW_CYCLES     = 50000000
) (
   input  logic                          ref_clk_clk,
   input  logic                          ref_reset_reset,
   input  logic [2:0]                    key_n,
   input  logic [DIGIT_W-1:0]            digit_in,
   input  logic                          prog_en,
   output logic [NUM_DIGITS*DIGIT_W-1:0] entry_buf,
   output logic [3:0]                    entry_cnt,
   output logic [2:0]                    state,
   output logic                          granted,
   output logic                          denied,
   output logic                          locked,
   output logic [3:0]                    fail_cnt,
   output logic                          pwd_updated
);

   localparam int unsigned BUF_W   = NUM_DIGITS * DIGIT_W;
   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TMR_MAX = (LOCK_CYCLES > SHOW_CYCLES) ? LOCK_CYCLES : SHOW_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_GRANTED = 3'd3,
      S_DENIED  = 3'd4,
      S_LOCKED  = 3'd5
   } state_t;

   // ---------------- key conditioning ----------------
   logic [2:0]      sync1, sync2, key_db, key_db_d;
   logic [DB_W-1:0] db_cnt [3];
   logic [2:0]      fall;
   logic            enter_ev, clear_ev, submit_ev;

   // A level is accepted only after DEBOUNCE_CYCLES consecutive samples that
   // differ from the current debounced level.
   always_ff @(posedge ref_clk_clk or negedge ref_reset_reset) begin
      if (!ref_reset_reset) begin
         sync1    <= '1;
         sync2    <= '1;
         key_db   <= '1;
         key_db_d <= '1;
         for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= key_n;
         sync2    <= sync1;
         key_db_d <= key_db;
         for (int unsigned i = 0; i < 3; i++) begin
            if (sync2[i] == key_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               key_db[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign fall      = key_db_d & ~key_db;
   assign clear_ev  = fall[1];
   assign submit_ev = fall[2] & ~fall[1];
   assign enter_ev  = fall[0] & ~fall[1] & ~fall[2];

   // ---------------- control FSM ----------------
   state_t             state_q, state_d;
   logic [BUF_W-1:0]   pwd, pwd_d, buf_d;
   logic [3:0]         cnt_d, fail_d;
   logic [TMR_W-1:0]   timer, tmr_d;
   logic               upd_d;
   logic               full;

   assign full  = (entry_cnt == 4'(NUM_DIGITS));
   assign state = state_q;

   always_ff @(posedge ref_clk_clk or negedge ref_reset_reset) begin
      if (!ref_reset_reset) begin
         state_q     <= S_IDLE;
         pwd         <= DEFAULT_PWD;
         entry_buf   <= '0;
         entry_cnt   <= '0;
         fail_cnt    <= '0;
         timer       <= '0;
         granted     <= 1'b0;
         denied      <= 1'b0;
         locked      <= 1'b0;
         pwd_updated <= 1'b0;
      end else begin
         state_q     <= state_d;
         pwd         <= pwd_d;
         entry_buf   <= buf_d;
         entry_cnt   <= cnt_d;
         fail_cnt    <= fail_d;
         timer       <= tmr_d;
         granted     <= (state_d == S_GRANTED);
         denied      <= (state_d == S_DENIED);
         locked      <= (state_d == S_LOCKED);
         pwd_updated <= upd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pwd_d   = pwd;
      buf_d   = entry_buf;
      cnt_d   = entry_cnt;
      fail_d  = fail_cnt;
      tmr_d   = timer;
      upd_d   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_ENTRY;
         S_ENTRY, S_GRANTED: begin
            // else-if chain enforces clear > submit > enter; a lower event
            // in the same cycle is dropped even when the higher one is ignored.
            if (clear_ev) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = S_ENTRY;
            end else if (submit_ev) begin
               if (full) begin
                  if (state_q == S_ENTRY) begin
                     state_d = S_CHECK;
                  end else if (prog_en) begin
                     pwd_d = entry_buf;
                     upd_d = 1'b1;
                     buf_d = '0;
                     cnt_d = '0;
                  end
               end
            end else if (enter_ev && !full) begin
               buf_d = (entry_buf << DIGIT_W) | BUF_W'(digit_in);
               cnt_d = entry_cnt + 4'd1;
            end
         end
         S_CHECK: begin
            buf_d = '0;
            cnt_d = '0;
            if (entry_buf == pwd) begin
               state_d = S_GRANTED;
               fail_d  = '0;
            end else begin
               fail_d = fail_cnt + 4'd1;
               if (fail_d == 4'(MAX_TRIES)) begin
                  state_d = S_LOCKED;
                  tmr_d   = TMR_W'(LOCK_CYCLES);
               end else begin
                  state_d = S_DENIED;
                  tmr_d   = TMR_W'(SHOW_CYCLES);
               end
            end
         end
         S_DENIED, S_LOCKED: begin
            // Timer is loaded with the full duration on entry, so leaving as
            // it steps to zero gives exactly that many cycles in the state.
            if (timer <= TMR_W'(1)) begin
               tmr_d   = '0;
               state_d = S_ENTRY;
               if (state_q == S_LOCKED) fail_d = '0;
            end else begin
               tmr_d = timer - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pwd_entry_ctrl.sv
// Testbench for pwd_entry_ctrl: directed key sequences against an abstract
// model (digit queue, stored password, failure count, nominal state).
module tb_pwd_entry_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  key_n = 3'b111;
   logic [3:0]  digit_in = '0;
   logic        prog_en = 1'b0;
   logic [15:0] entry_buf;
   logic [3:0]  entry_cnt;
   logic [2:0]  state;
   logic        granted, denied, locked;
   logic [3:0]  fail_cnt;
   logic        pwd_updated;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pwd_entry_ctrl #(
      .NUM_DIGITS(4), .DIGIT_W(4), .DEFAULT_PWD(16'h1234), .MAX_TRIES(3),
      .DEBOUNCE_CYCLES(4), .LOCK_CYCLES(100), .SHOW_CYCLES(8)
   ) dut (
      .ref_clk_clk(clk), .ref_reset_reset(rst_n), .key_n(key_n),
      .digit_in(digit_in), .prog_en(prog_en), .entry_buf(entry_buf),
      .entry_cnt(entry_cnt), .state(state), .granted(granted),
      .denied(denied), .locked(locked), .fail_cnt(fail_cnt),
      .pwd_updated(pwd_updated)
   );

   // ---------------- abstract model ----------------
   int          m_state = 0;
   int          m_digits[$];
   logic [15:0] m_pwd = 16'h1234;
   int          m_fail = 0;
   bit          chk_en = 1'b0;

   function automatic logic [15:0] m_buf();
      logic [15:0] v = '0;
      foreach (m_digits[i]) v = v * 16 + 16'(m_digits[i]);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle the model is settled, the outputs must match it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (chk_en) begin
            chk("state", 32'(state), 32'(m_state));
            chk("entry_buf", 32'(entry_buf), 32'(m_buf()));
            chk("entry_cnt", 32'(entry_cnt), 32'(m_digits.size()));
            chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
            chk("granted", 32'(granted), 32'(m_state == 3));
            chk("denied", 32'(denied), 32'(m_state == 4));
            chk("locked", 32'(locked), 32'(m_state == 5));
            chk("pwd_updated_idle", 32'(pwd_updated), 32'd0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic press(input logic [2:0] mask);
      chk_en = 1'b0;
      @(negedge clk);
      key_n = ~mask;
      repeat (10) @(negedge clk);
      key_n = 3'b111;
      repeat (12) @(negedge clk);
   endtask

   task automatic enter(input int d);
      digit_in = 4'(d);
      press(3'b001);
      if ((m_state == 1 || m_state == 3) && m_digits.size() < 4) m_digits.push_back(d);
      chk_en = 1'b1;
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      enter(a); enter(b); enter(c); enter(d);
   endtask

   task automatic clear_key();
      press(3'b010);
      if (m_state == 1 || m_state == 3) begin
         m_digits.delete();
         m_state = 1;
      end
      chk_en = 1'b1;
   endtask

   // Submit that must change nothing.
   task automatic submit_ignored();
      press(3'b100);
      chk_en = 1'b1;
   endtask

   // Submit from ENTRY with a full buffer; checks CHECK length and the
   // duration of any DENIED/LOCKED period that follows.
   task automatic attempt();
      bit match;
      int exp_st, n, wt;
      match = (m_buf() == m_pwd);
      chk_en = 1'b0;
      @(negedge clk);
      key_n = 3'b011;
      wt = 0;
      while (state !== 3'd2 && wt < 40) begin
         @(negedge clk);
         wt++;
      end
      chk("check_reached", 32'(state), 32'd2);
      key_n = 3'b111;
      m_digits.delete();
      @(negedge clk);
      if (match) begin
         m_fail = 0;
         m_state = 3;
         chk("after_check", 32'(state), 32'd3);
         chk("granted_on_entry", 32'(granted), 32'd1);
      end else begin
         m_fail++;
         exp_st = (m_fail == 3) ? 5 : 4;
         chk("after_check", 32'(state), 32'(exp_st));
         chk("fail_after_check", 32'(fail_cnt), 32'(m_fail));
         chk("denied_on_entry", 32'(denied), 32'(exp_st == 4));
         chk("locked_on_entry", 32'(locked), 32'(exp_st == 5));
         n = 1;
         while (n < 300) begin
            @(negedge clk);
            if (state !== 3'(exp_st)) break;
            n++;
            // keys pressed during lockout must be ignored
            if (exp_st == 5) begin
               if (n == 20) key_n = 3'b110;
               if (n == 35) key_n = 3'b111;
               if (n == 50) key_n = 3'b101;
               if (n == 65) key_n = 3'b111;
            end
         end
         chk("timed_duration", 32'(n), (exp_st == 4) ? 32'd8 : 32'd100);
         chk("back_to_entry", 32'(state), 32'd1);
         if (exp_st == 5) m_fail = 0;
         m_state = 1;
      end
      chk("cnt_after_attempt", 32'(entry_cnt), 32'd0);
      repeat (12) @(negedge clk);
      chk_en = 1'b1;
   endtask

   task automatic program_pwd();
      int wt;
      chk_en = 1'b0;
      prog_en = 1'b1;
      @(negedge clk);
      key_n = 3'b011;
      wt = 0;
      while (pwd_updated !== 1'b1 && wt < 40) begin
         @(negedge clk);
         wt++;
      end
      chk("pwd_updated_pulse", 32'(pwd_updated), 32'd1);
      key_n = 3'b111;
      @(negedge clk);
      chk("pwd_updated_one_cycle", 32'(pwd_updated), 32'd0);
      chk("prog_stays_granted", 32'(state), 32'd3);
      chk("prog_clears_cnt", 32'(entry_cnt), 32'd0);
      m_pwd = m_buf();
      m_digits.delete();
      prog_en = 1'b0;
      repeat (12) @(negedge clk);
      chk_en = 1'b1;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      key_n = 3'b111;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_buf", 32'(entry_buf), 32'd0);
      chk("rst_cnt", 32'(entry_cnt), 32'd0);
      chk("rst_fail", 32'(fail_cnt), 32'd0);
      chk("rst_flags", 32'({granted, denied, locked, pwd_updated}), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rst_release_idle", 32'(state), 32'd0);
      @(negedge clk);
      chk("idle_to_entry", 32'(state), 32'd1);
      m_state = 1;
      m_digits.delete();
      m_fail = 0;
      m_pwd = 16'h1234;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();

      // Overflow: fifth digit dropped
      enter4(1, 2, 3, 4);
      enter(9);
      chk("lit_overflow_buf", 32'(entry_buf), 32'h1234);
      chk("lit_overflow_cnt", 32'(entry_cnt), 32'd4);

      // Short submit is ignored
      clear_key();
      enter(1); enter(2); enter(3);
      submit_ignored();
      chk("lit_short_state", 32'(state), 32'd1);
      chk("lit_short_buf", 32'(entry_buf), 32'h0123);

      // 3-cycle bounce on enter: no event
      @(negedge clk);
      key_n = 3'b110;
      repeat (3) @(negedge clk);
      key_n = 3'b111;
      repeat (15) @(negedge clk);
      chk("lit_bounce_cnt", 32'(entry_cnt), 32'd3);

      // Clear and enter together: clear wins
      digit_in = 4'd7;
      press(3'b011);
      m_digits.delete();
      chk_en = 1'b1;
      chk("lit_clear_enter_cnt", 32'(entry_cnt), 32'd0);

      // Three wrong attempts: DENIED, DENIED, LOCKED
      repeat (3) begin
         enter4(1, 2, 3, 5);
         attempt();
      end
      chk("lit_after_lock_fail", 32'(fail_cnt), 32'd0);

      // Correct password
      enter4(1, 2, 3, 4);
      attempt();
      chk("lit_granted", 32'(granted), 32'd1);

      // Reprogram while GRANTED
      enter(9); enter(8); enter(7); enter(6);
      submit_ignored();                 // prog_en low: no effect
      program_pwd();
      clear_key();
      enter4(9, 8, 7, 6);
      attempt();
      chk("lit_new_pwd_granted", 32'(state), 32'd3);

      // Reset restores the default password
      do_reset();
      enter4(9, 8, 7, 6);
      attempt();
      chk("lit_old_pwd_fail", 32'(fail_cnt), 32'd1);
      enter4(1, 2, 3, 4);
      attempt();
      chk("lit_default_granted", 32'(granted), 32'd1);

      // Reset mid-entry
      clear_key();
      enter(1); enter(2);
      do_reset();

      // Reset during LOCKED
      repeat (2) begin
         enter4(1, 1, 1, 1);
         attempt();
      end
      enter4(1, 1, 1, 1);
      begin
         int wt;
         chk_en = 1'b0;
         @(negedge clk);
         key_n = 3'b011;
         wt = 0;
         while (state !== 3'd5 && wt < 40) begin
            @(negedge clk);
            wt++;
         end
         chk("lock_reached", 32'(state), 32'd5);
         key_n = 3'b111;
         repeat (30) @(negedge clk);
      end
      do_reset();
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
